// File: rtl/fp_div_pkg.sv
// Shared types and constants for the floating-point divider round/pack stage.
package fp_div_pkg;

    localparam int EXP_BIAS = 127;
    localparam int EXP_W    = 10;
    localparam int QUOT_W   = 26;
    localparam int MANT_W   = 23;
    localparam int XEXP_W   = EXP_W + 2;      // headroom for the -1 normalise step and rounding carry
    localparam int EXP_MAX  = 2 * EXP_BIAS + 1;

    localparam logic [31:0] FP_QNAN    = 32'h7FC00000;
    localparam logic [7:0]  FP_INF_EXP = 8'hFF;

    typedef enum logic [1:0] {
        SPECIAL_NORMAL = 2'b00,
        SPECIAL_ZERO   = 2'b01,
        SPECIAL_INF    = 2'b10,
        SPECIAL_NAN    = 2'b11
    } special_e;

    typedef struct packed {
        logic              sign;
        logic [XEXP_W-1:0] exp;
        logic [MANT_W-1:0] mant;
        logic              guard;
        logic              sticky;
        special_e          special;
    } norm_t;

endpackage

// File: rtl/fp_div_round_rne.sv
// Round-to-nearest-even on a 23-bit fraction; carry-out wraps the fraction to zero.
module fp_round_rne
    import fp_div_pkg::*;
(
    input  logic [MANT_W-1:0] mant,
    input  logic              guard,
    input  logic              sticky,
    output logic [MANT_W-1:0] mant_rnd,
    output logic              carry,
    output logic              inexact
);

    logic round_up;

    assign round_up            = guard && (sticky || mant[0]);
    assign {carry, mant_rnd}   = {1'b0, mant} + {{MANT_W{1'b0}}, round_up};
    assign inexact             = guard || sticky;

endmodule

// File: rtl/fp_div_round.sv
// Two-stage normalise + round/pack back end of an IEEE754 single divider.
// Define FP_DIV_ROUND_FLAGS_EN to add the out_flags port and its pipeline.
module fp_div_round
    import fp_div_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_sign,
    input  logic [EXP_W-1:0]      in_exp,
    input  logic [QUOT_W-1:0]     in_quot,
    input  logic                  in_sticky,
    input  logic [1:0]            in_special,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data
`ifdef FP_DIV_ROUND_FLAGS_EN
    ,
    output logic [3:0]            out_flags
`endif
);

    logic                  en;
    logic                  s1_valid_reg;
    logic                  s2_valid_reg;
    norm_t                 s1_reg;
    norm_t                 s1_next;
    logic [XEXP_W-1:0]     exp_ext;
    logic [DATA_WIDTH-1:0] out_data_reg;
    logic [DATA_WIDTH-1:0] s2_data_next;
    logic [MANT_W-1:0]     rnd_mant;
    logic                  rnd_carry;
    logic                  rnd_inexact;
    logic [XEXP_W-1:0]     exp_final;
    logic                  is_ovf;
    logic                  is_unf;

    // Whole pipe moves together; only a stalled, full output stage blocks it.
    assign en        = !s2_valid_reg || out_ready;
    assign in_ready  = en;
    assign out_valid = s2_valid_reg;
    assign out_data  = out_data_reg;

    assign exp_ext = {{(XEXP_W-EXP_W){in_exp[EXP_W-1]}}, in_exp};

    always_comb begin
        s1_next         = '0;
        s1_next.sign    = in_sign;
        s1_next.special = special_e'(in_special);
        if (in_quot[25]) begin
            s1_next.mant   = in_quot[24:2];
            s1_next.guard  = in_quot[1];
            s1_next.sticky = in_quot[0] | in_sticky;
            s1_next.exp    = exp_ext;
        end else begin
            s1_next.mant   = in_quot[23:1];
            s1_next.guard  = in_quot[0];
            s1_next.sticky = in_sticky;
            s1_next.exp    = exp_ext - XEXP_W'(1);
        end
        // A quotient without a leading one cannot be normalised; emit a clean zero.
        if (s1_next.special == SPECIAL_NORMAL && in_quot[25:24] == 2'b00) begin
            s1_next.special = SPECIAL_ZERO;
        end
    end

    fp_round_rne u_round (
        .mant     (s1_reg.mant),
        .guard    (s1_reg.guard),
        .sticky   (s1_reg.sticky),
        .mant_rnd (rnd_mant),
        .carry    (rnd_carry),
        .inexact  (rnd_inexact)
    );

    assign exp_final = s1_reg.exp + XEXP_W'(rnd_carry);
    assign is_ovf    = $signed(exp_final) >= $signed(XEXP_W'(EXP_MAX));
    assign is_unf    = $signed(exp_final) <= $signed(XEXP_W'(0));

    always_comb begin
        s2_data_next = '0;
        case (s1_reg.special)
            SPECIAL_NAN:  s2_data_next = FP_QNAN;
            SPECIAL_INF:  s2_data_next = {s1_reg.sign, FP_INF_EXP, 23'h0};
            SPECIAL_ZERO: s2_data_next = {s1_reg.sign, 31'h0};
            default: begin
                if (is_ovf) begin
                    s2_data_next = {s1_reg.sign, FP_INF_EXP, 23'h0};
                end else if (is_unf) begin
                    s2_data_next = {s1_reg.sign, 31'h0};
                end else begin
                    s2_data_next = {s1_reg.sign, exp_final[7:0], rnd_mant};
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s2_valid_reg <= 1'b0;
            out_data_reg <= '0;
        end else if (en) begin
            s1_valid_reg <= in_valid;
            s2_valid_reg <= s1_valid_reg;
            if (in_valid) begin
                s1_reg <= s1_next;
            end
            if (s1_valid_reg) begin
                out_data_reg <= s2_data_next;
            end
        end
    end

`ifdef FP_DIV_ROUND_FLAGS_EN
    // Flag order: {invalid, overflow, underflow, inexact}
    logic [3:0] flags_next;
    logic [3:0] flags_reg;

    always_comb begin
        flags_next = 4'b0000;
        case (s1_reg.special)
            SPECIAL_NAN:  flags_next = 4'b1000;
            SPECIAL_INF,
            SPECIAL_ZERO: flags_next = 4'b0000;
            default: begin
                if (is_ovf) begin
                    flags_next = 4'b0101;
                end else if (is_unf) begin
                    flags_next = 4'b0011;
                end else begin
                    flags_next = {3'b000, rnd_inexact};
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_reg <= 4'b0000;
        end else if (en && s1_valid_reg) begin
            flags_reg <= flags_next;
        end
    end

    assign out_flags = flags_reg;
`else
    logic unused_inexact;
    assign unused_inexact = rnd_inexact;
`endif

endmodule

// File: tb/tb_fp_div_round.sv
// Self-checking bench for fp_div_round: directed corners, streaming with random stalls, reset under stall.
module tb_fp_div_round;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [9:0]  in_exp;
    logic [25:0] in_quot;
    logic        in_sticky;
    logic [1:0]  in_special;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  flags_obs;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

`ifdef FP_DIV_ROUND_FLAGS_EN
    logic [3:0] out_flags;
    assign flags_obs = out_flags;
`else
    assign flags_obs = 4'b0000;
`endif

    fp_div_round #(.DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_quot    (in_quot),
        .in_sticky  (in_sticky),
        .in_special (in_special),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data)
`ifdef FP_DIV_ROUND_FLAGS_EN
        ,
        .out_flags  (out_flags)
`endif
    );

    // Reference: treat the quotient as an integer, drop the low bits and round the
    // dropped remainder against exactly one half of the last kept unit.
    function automatic void ref_model(input logic s, input logic [9:0] e_in, input logic [25:0] q_in,
                                      input logic st, input logic [1:0] sp,
                                      output logic [31:0] d, output logic [3:0] f);
        int     e;
        int     shift;
        longint q, kept, rem, half;
        bit     up, exact;
        d = 32'h0;
        f = 4'b0000;
        if (sp == 2'b11) begin
            d = 32'h7FC00000;
            f = 4'b1000;
        end else if (sp == 2'b10) begin
            d = {s, 8'hFF, 23'h0};
        end else if (sp == 2'b01 || q_in < 26'h1000000) begin
            d = {s, 31'h0};
        end else begin
            e     = int'($signed(e_in));
            q     = longint'(q_in);
            shift = (q >= (longint'(1) << 25)) ? 2 : 1;
            if (shift == 1) e = e - 1;
            kept  = q >> shift;
            rem   = q - (kept << shift);
            half  = longint'(1) << (shift - 1);
            exact = (rem == 0) && !st;
            up    = (rem > half) || (rem == half && (st || (kept % 2 == 1)));
            if (up) kept = kept + 1;
            if (kept == (longint'(1) << 24)) begin
                kept = kept / 2;
                e    = e + 1;
            end
            if (e >= 255) begin
                d = {s, 8'hFF, 23'h0};
                f = 4'b0101;
            end else if (e <= 0) begin
                d = {s, 31'h0};
                f = 4'b0011;
            end else begin
                d = {s, 8'(e), 23'(kept)};
                f = {3'b000, !exact};
            end
        end
    endfunction

    task automatic gen_item(output logic s, output logic [9:0] e, output logic [25:0] q,
                            output logic st, output logic [1:0] sp);
        int r;
        s  = 1'($urandom);
        st = 1'($urandom);
        r  = $urandom_range(0, 9);
        if (r == 0)      e = 10'($urandom_range(250, 260));
        else if (r == 1) e = 10'(int'($urandom_range(0, 6)) - 3);
        else if (r == 2) e = 10'($urandom);
        else             e = 10'($urandom_range(1, 254));
        q = 26'($urandom);
        r = $urandom_range(0, 19);
        if (r < 13)      q[25] = 1'b1;
        else if (r < 19) q[25:24] = 2'b01;
        else             q[25:24] = 2'b00;
        r  = $urandom_range(0, 19);
        sp = (r < 17) ? 2'b00 : 2'($urandom_range(1, 3));
    endtask

    task automatic drive_in(input logic s, input logic [9:0] e, input logic [25:0] q,
                            input logic st, input logic [1:0] sp);
        in_valid   = 1'b1;
        in_sign    = s;
        in_exp     = e;
        in_quot    = q;
        in_sticky  = st;
        in_special = sp;
    endtask

    // Starts and ends at posedge+1; returns the cycle count until out_valid.
    task automatic send_one(input logic s, input logic [9:0] e, input logic [25:0] q,
                            input logic st, input logic [1:0] sp,
                            output logic [31:0] d, output logic [3:0] f, output int lat);
        drive_in(s, e, q, st, sp);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        d = out_data;
        f = flags_obs;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drive_in(1'b0, 10'd0, 26'd0, 1'b0, 2'b00);
        in_valid  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        checks++;
        if (out_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_out_data: got %h want 00000000", out_data);
        end
`ifdef FP_DIV_ROUND_FLAGS_EN
        checks++;
        if (flags_obs !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 0000", flags_obs);
        end
`endif
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic        s;
        logic [9:0]  e;
        logic [25:0] q;
        logic        st;
        logic [1:0]  sp;
        logic [31:0] d;
        logic [3:0]  f;
    } dvec_t;

    task automatic test_directed();
        dvec_t       v[11];
        logic [31:0] d;
        logic [3:0]  f;
        int          lat;
        v[0]  = '{1'b0, 10'd127,  26'h2000000, 1'b0, 2'b00, 32'h3F800000, 4'b0000};
        v[1]  = '{1'b0, 10'd127,  26'h3FFFFFE, 1'b0, 2'b00, 32'h40000000, 4'b0001};
        v[2]  = '{1'b0, 10'd127,  26'h2000002, 1'b0, 2'b00, 32'h3F800000, 4'b0001};
        v[3]  = '{1'b1, 10'd300,  26'h2000000, 1'b0, 2'b00, 32'hFF800000, 4'b0101};
        v[4]  = '{1'b0, 10'd1,    26'h1000000, 1'b0, 2'b00, 32'h00000000, 4'b0011};
        v[5]  = '{1'b0, 10'd127,  26'h3FFFFFF, 1'b1, 2'b11, 32'h7FC00000, 4'b1000};
        v[6]  = '{1'b1, 10'd5,    26'h2000000, 1'b0, 2'b01, 32'h80000000, 4'b0000};
        v[7]  = '{1'b0, 10'd127,  26'h0FFFFFF, 1'b1, 2'b00, 32'h00000000, 4'b0000};
        v[8]  = '{1'b1, 10'd127,  26'h2000000, 1'b0, 2'b10, 32'hFF800000, 4'b0000};
        v[9]  = '{1'b0, 10'd127,  26'h2000002, 1'b1, 2'b00, 32'h3F800001, 4'b0001};
        v[10] = '{1'b0, 10'h3FF,  26'h2000000, 1'b0, 2'b00, 32'h00000000, 4'b0011};
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            send_one(v[i].s, v[i].e, v[i].q, v[i].st, v[i].sp, d, f, lat);
            checks++;
            if (lat !== 2) begin
                errors++;
                $display("FAIL directed_latency[%0d]: got %0d cycles want 2", i, lat);
            end
            checks++;
            if (d !== v[i].d) begin
                errors++;
                $display("FAIL directed_data[%0d]: got %h want %h", i, d, v[i].d);
            end
`ifdef FP_DIV_ROUND_FLAGS_EN
            checks++;
            if (f !== v[i].f) begin
                errors++;
                $display("FAIL directed_flags[%0d]: got %b want %b", i, f, v[i].f);
            end
`endif
            $display("directed[%0d] exp=%0d quot=%h sp=%b -> data=%h flags=%b lat=%0d", i,
                     $signed(v[i].e), v[i].q, v[i].sp, d, f, lat);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic        s[3], st[3];
        logic [9:0]  e[3];
        logic [25:0] q[3];
        logic [1:0]  sp[3];
        logic [31:0] ed[3];
        logic [3:0]  ef[3];
        int          idx = 0, got = 0;
        bit          saw_stall = 0, hold = 0;
        logic [31:0] hold_d;
        for (int i = 0; i < 3; i++) begin
            gen_item(s[i], e[i], q[i], st[i], sp[i]);
            ref_model(s[i], e[i], q[i], st[i], sp[i], ed[i], ef[i]);
        end
        for (int cyc = 0; cyc < 40 && got < 3; cyc++) begin
            out_ready = (cyc >= 4);
            if (idx < 3) drive_in(s[idx], e[idx], q[idx], st[idx], sp[idx]);
            else         in_valid = 1'b0;
            @(negedge clk);
            if (hold) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== hold_d) begin
                    errors++;
                    $display("FAIL b2b_hold: got valid=%b data=%h want valid=1 data=%h", out_valid, out_data, hold_d);
                end
            end
            hold   = out_valid && !out_ready;
            hold_d = out_data;
            if (in_valid && !in_ready) saw_stall = 1;
            if (in_valid && in_ready) idx++;
            if (out_valid && out_ready) begin
                checks++;
                if (out_data !== ed[got]) begin
                    errors++;
                    $display("FAIL b2b_data[%0d]: got %h want %h", got, out_data, ed[got]);
                end
`ifdef FP_DIV_ROUND_FLAGS_EN
                checks++;
                if (flags_obs !== ef[got]) begin
                    errors++;
                    $display("FAIL b2b_flags[%0d]: got %b want %b", got, flags_obs, ef[got]);
                end
`endif
                $display("b2b[%0d] cycle=%0d data=%h expect=%h", got, cyc, out_data, ed[got]);
                got++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks++;
        if (saw_stall !== 1'b1) begin
            errors++;
            $display("FAIL b2b_backpressure: in_ready low seen=%0d want 1", saw_stall);
        end
        checks++;
        if (got !== 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d results want 3", got);
        end
    endtask

    task automatic test_random(input int n);
        logic [31:0] exp_d_q[$];
        logic [3:0]  exp_f_q[$];
        logic        s, st;
        logic [9:0]  e;
        logic [25:0] q;
        logic [1:0]  sp;
        logic [31:0] md, wd;
        logic [3:0]  mf, wf;
        logic [31:0] hold_d;
        bit          hold = 0;
        int          sent = 0, recv = 0, cyc = 0;
        gen_item(s, e, q, st, sp);
        while ((sent < n || recv < sent) && cyc < 5000) begin
            out_ready = ($urandom_range(0, 9) < 7) || (sent >= n);
            drive_in(s, e, q, st, sp);
            in_valid = (sent < n) && ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (hold) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== hold_d) begin
                    errors++;
                    $display("FAIL rand_hold: got valid=%b data=%h want valid=1 data=%h", out_valid, out_data, hold_d);
                end
            end
            hold   = out_valid && !out_ready;
            hold_d = out_data;
            if (in_valid && in_ready) begin
                ref_model(s, e, q, st, sp, md, mf);
                exp_d_q.push_back(md);
                exp_f_q.push_back(mf);
                sent++;
                gen_item(s, e, q, st, sp);
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_d_q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_spurious: got output %h want none pending", out_data);
                end else begin
                    wd = exp_d_q.pop_front();
                    wf = exp_f_q.pop_front();
                    if (out_data !== wd) begin
                        errors++;
                        $display("FAIL rand_data[%0d]: got %h want %h", recv, out_data, wd);
                    end
`ifdef FP_DIV_ROUND_FLAGS_EN
                    checks++;
                    if (flags_obs !== wf) begin
                        errors++;
                        $display("FAIL rand_flags[%0d]: got %b want %b", recv, flags_obs, wf);
                    end
`endif
                    $display("rand[%0d] data=%h expect=%h flags=%b expect=%b", recv, out_data, wd, flags_obs, wf);
                end
                recv++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (recv !== n) begin
            errors++;
            $display("FAIL rand_count: got %0d results want %0d within cycle budget", recv, n);
        end
    endtask

    task automatic test_stall_reset();
        logic        s, st;
        logic [9:0]  e;
        logic [25:0] q;
        logic [1:0]  sp;
        int          wait_cyc = 0;
        out_ready = 1'b0;
        gen_item(s, e, q, st, sp);
        drive_in(s, e, q, 1'b0, 2'b10);
        @(posedge clk); #1;
        in_valid = 1'b0;
        while (!out_valid && wait_cyc < 10) begin
            @(posedge clk); #1;
            wait_cyc++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_rst_setup: got out_valid=%b want 1", out_valid);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_rst: got valid=%b data=%h in_ready=%b want 0 00000000 1", out_valid, out_data, in_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_rst_release: got in_ready=%b valid=%b want 1 0", in_ready, out_valid);
        end
        $display("stall_rst valid=%b data=%h in_ready=%b", out_valid, out_data, in_ready);
        @(posedge clk); #1;
        out_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random(300);
        test_stall_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fp_div_round.md
FP_DIV_ROUND -- requirements
Module: fp_div_round

Interface
REQ-001 SHALL have parameter: DATA_WIDTH, 32, packed IEEE754 single result width (only 32 supported).
REQ-002 SHALL have the following ports, in order:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  upstream divider result valid.
- in_ready  output  1  stage accepts input this cycle.
- in_sign  input  1  result sign (sign_a XOR sign_b).
- in_exp  input  10  signed biased exponent, exp_a - exp_b + 127.
- in_quot  input  26  quotient q in [0.5,2) scaled by 2^25; bit25 or bit24 is the leading one.
- in_sticky  input  1  divider remainder nonzero.
- in_special  input  2  00 normal, 01 zero, 10 inf, 11 NaN (from operand classifier).
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_data  output  DATA_WIDTH  packed IEEE754 result.
- out_flags  output  4  {invalid, overflow, underflow, inexact}; present only with FP_DIV_ROUND_FLAGS_EN.

Function
REQ-003 SHALL be a 2-stage pipeline: S1 normalize, S2 round/pack; latency exactly 2 cycles from accepted input to out_valid when unstalled.
REQ-004 SHALL use global enable en = !s2_valid || out_ready; in_ready = en; both stages advance only when en=1.
REQ-005 SHALL hold out_data/out_valid stable while out_valid=1 and out_ready=0; no drop, duplicate or reordering.
REQ-006 SHALL accept one input per cycle at full throughput when out_ready is held high.
REQ-007 S1: if in_quot[25]=1, mantissa=in_quot[24:2], guard=in_quot[1], sticky=in_quot[0]|in_sticky, exponent=in_exp.
REQ-008 S1: else mantissa=in_quot[23:1], guard=in_quot[0], sticky=in_sticky, exponent=in_exp-1.
REQ-009 S2 SHALL round to nearest, ties to even: increment when guard && (sticky || mantissa[0]).
REQ-010 Mantissa carry-out from rounding SHALL clear the mantissa and increment the exponent.
REQ-011 Final exponent >= 255 SHALL output {sign,8'hFF,23'h0} and set overflow and inexact.
REQ-012 Final exponent <= 0 SHALL output {sign,31'h0} (flush-to-zero, no subnormals) and set underflow and inexact.
REQ-013 in_special overrides arithmetic:
- zero -> {sign,31'h0}.
- inf -> {sign,8'hFF,23'h0}.
- NaN -> 32'h7FC00000 with invalid set.
- No other flags set on special outputs.
REQ-014 inexact SHALL be guard||sticky for normal results.
REQ-015 in_quot with bits 25:24 both zero on a normal input SHALL be treated as zero result (defensive), no flags.

Reset
REQ-016 On rst=1 at a clock edge: S1/S2 valid cleared, out_valid=0, out_data=0, out_flags=0; in-flight data discarded.
REQ-017 rst SHALL take priority over en and out_ready; in_ready SHALL be 1 in the first cycle after reset release.

Configuration
REQ-018 Macro FP_DIV_ROUND_FLAGS_EN defined: out_flags port and flag pipeline registers exist per REQ-011..014.
REQ-019 Macro FP_DIV_ROUND_FLAGS_EN undefined: out_flags port and flag logic absent; out_data timing and values identical.

Structure
REQ-020 Package fp_div_pkg SHALL hold:
- special-code enum.
- constants EXP_BIAS=127, EXP_W=10, QUOT_W=26.
- FP_QNAN=32'h7FC00000, FP_INF_EXP=8'hFF.
REQ-021 Sub-module fp_round_rne (combinational: mantissa, guard, sticky -> rounded mantissa, carry, inexact) SHALL be instantiated in S2.

Verification
REQ-022 The bench SHALL cover the following directed scenarios:
- exp=127, quot=26'h2000000, sticky=0, normal -> out_data=32'h3F800000 exactly 2 cycles later, flags 0.
- exp=127, quot=26'h3FFFFFE, sticky=0 (tie, lsb=1) -> 32'h40000000 (round carry), inexact=1; same with quot=26'h2000002 (tie, lsb=0) -> 32'h3F800000.
- exp=300, sign=1 -> 32'hFF800000, overflow=1; exp=1 with quot[25]=0 (bit24 set) -> 32'h00000000, underflow=1.
- in_special=11 with any data -> 32'h7FC00000, invalid=1; in_special=01, sign=1 -> 32'h80000000.
- 3 back-to-back inputs, out_ready low 4 cycles -> in_ready low after pipeline fills, all 3 results emitted in order, none lost.
- rst asserted while out_valid=1 and stalled -> next cycle out_valid=0, out_data=0, in_ready=1.
